// File: rtl/pwm_duty_decode.sv
// PWM receiver: recovers the 11-bit duty word from an asynchronous PWM line,
// checks each period against the nominal frame and flags a stuck line.
module pwm_duty_decode #(
    parameter int unsigned PERIOD  = 2048,
    parameter int unsigned TOL     = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [10:0] duty,
    output logic        duty_vld,
    output logic        period_err,
    output logic        stuck_hi,
    output logic        stuck_lo
);

    localparam logic [12:0] TIMEOUT_C = 13'(TIMEOUT);
    localparam logic [12:0] PER_LO    = 13'(PERIOD - TOL);
    localparam logic [12:0] PER_HI    = 13'(PERIOD + TOL);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    state_t      state, state_d;
    logic        sync1, sync2, prev;
    logic [1:0]  fill;
    logic [12:0] per_cnt, per_cnt_d;
    logic [11:0] hi_cnt, hi_cnt_d;
    logic [10:0] duty_d;
    logic        duty_vld_d, period_err_d, stuck_hi_d, stuck_lo_d;
    logic        rise, in_tol, timeout;

    // prev is held at 1 until sync2 carries a real sample, so a line that is
    // already high at reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b1;
            fill  <= '0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            prev  <= fill[1] ? sync2 : 1'b1;
        end
    end

    assign rise    = sync2 & ~prev;
    assign in_tol  = (per_cnt >= PER_LO) && (per_cnt <= PER_HI);
    assign timeout = ~rise && (per_cnt == TIMEOUT_C) && ~stuck_hi && ~stuck_lo;

    always_comb begin
        state_d      = state;
        per_cnt_d    = (per_cnt == TIMEOUT_C) ? per_cnt : per_cnt + 13'd1;
        hi_cnt_d     = (sync2 && (hi_cnt != '1)) ? hi_cnt + 12'd1 : hi_cnt;
        duty_d       = duty;
        duty_vld_d   = 1'b0;
        period_err_d = 1'b0;
        stuck_hi_d   = stuck_hi;
        stuck_lo_d   = stuck_lo;

        if (rise) begin
            per_cnt_d  = 13'd1;
            hi_cnt_d   = 12'd1;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
            state_d    = MEAS;
            if (state == MEAS) begin
                if (in_tol) begin
                    duty_d     = hi_cnt[11] ? '1 : hi_cnt[10:0];
                    duty_vld_d = 1'b1;
                end else begin
                    period_err_d = 1'b1;
                end
            end
        end else if (timeout) begin
            state_d    = IDLE;
            duty_vld_d = 1'b1;
            stuck_hi_d = sync2;
            stuck_lo_d = ~sync2;
            duty_d     = sync2 ? '1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            duty       <= '0;
            duty_vld   <= 1'b0;
            period_err <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            state      <= state_d;
            per_cnt    <= per_cnt_d;
            hi_cnt     <= hi_cnt_d;
            duty       <= duty_d;
            duty_vld   <= duty_vld_d;
            period_err <= period_err_d;
            stuck_hi   <= stuck_hi_d;
            stuck_lo   <= stuck_lo_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_decode.sv
// Scoreboard bench for pwm_duty_decode: a period/high-time model predicts
// every duty_vld / period_err pulse; a negedge monitor checks them.
module tb_pwm_duty_decode;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [10:0] duty;
    logic        duty_vld, period_err, stuck_hi, stuck_lo;

    pwm_duty_decode #(.PERIOD(2048), .TOL(2), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty(duty),
        .duty_vld(duty_vld), .period_err(period_err),
        .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [10:0] duty;
        bit          shi;
        bit          slo;
        int          cyc;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;
    logic [10:0] exp_duty = '0;

    // reference model state: times are in bench cycles of the pwm_in changes
    bit m_idle, m_timed_out;
    int m_last_k, m_hi_until, m_deadline;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(input bit err, input int d, input bit shi,
                                    input bit slo, input int c);
        ev_t e;
        e.err  = err;
        e.duty = 11'(d);
        e.shi  = shi;
        e.slo  = slo;
        e.cyc  = c;
        q.push_back(e);
    endfunction

    function automatic void model_reset(input int c0, input logic lvl);
        m_idle      = 1'b1;
        m_timed_out = 1'b0;
        m_last_k    = c0;
        m_deadline  = c0 + 4097;
        m_hi_until  = lvl ? BIG : c0;
    endfunction

    function automatic void model_rise(input int k);
        int p, h;
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            p = k - m_last_k;
            h = m_hi_until - m_last_k;
            if (p >= 2046 && p <= 2050)
                push_ev(1'b0, (h > 2047) ? 2047 : h, 1'b0, 1'b0, k + 3);
            else
                push_ev(1'b1, 0, 1'b0, 1'b0, k + 3);
        end
        m_last_k    = k;
        m_hi_until  = BIG;
        m_deadline  = k + 4099;
        m_timed_out = 1'b0;
    endfunction

    task automatic step(input logic v);
        @(posedge clk);
        #1;
        if (v && !pwm_in) begin
            model_rise(cyc);
        end else begin
            if (!v && pwm_in) m_hi_until = cyc;
            if (!m_timed_out && cyc == m_deadline - 3) begin
                push_ev(1'b0, v ? 2047 : 0, v, !v, m_deadline);
                m_timed_out = 1'b1;
                m_idle      = 1'b1;
            end
        end
        pwm_in = v;
    endtask

    task automatic run_period(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) step(logic'(i < h));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(cyc, pwm_in);
    endtask

    task automatic do_reset(input int n);
        check("queue_empty_before_reset", q.size(), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {duty, duty_vld, period_err, stuck_hi, stuck_lo}, 0);
        repeat (n) @(posedge clk);
        release_reset();
    endtask

    always @(negedge clk) begin
        ev_t e;
        logic [14:0] exp_vec;
        if (!rst_n) begin
            exp_duty = '0;
        end else if (duty_vld || period_err) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {period_err, duty_vld}, 0);
            end else begin
                e = q.pop_front();
                exp_vec = {e.err, ~e.err, e.err ? exp_duty : e.duty, e.shi, e.slo};
                check("event_err_vld_duty_hi_lo",
                      {period_err, duty_vld, duty, stuck_hi, stuck_lo}, int'(exp_vec));
                check("event_cycle", cyc, e.cyc);
                if (!e.err) exp_duty = e.duty;
            end
        end else begin
            check("duty_hold", duty, exp_duty);
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // line low from reset: stuck_lo timeout, then normal D=512
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {duty, duty_vld, period_err, stuck_hi, stuck_lo}, 0);
        release_reset();
        for (int i = 0; i < 4200; i++) step(1'b0);
        check("stuck_lo_set", stuck_lo, 1);
        check("stuck_hi_clear", stuck_hi, 0);
        run_period(2048, 512, 2048);
        check("stuck_lo_cleared", stuck_lo, 0);
        for (int i = 0; i < 3; i++) run_period(2048, 512, 2048);

        // extremes of the duty range
        for (int i = 0; i < 3; i++) run_period(2048, 2047, 2048);
        for (int i = 0; i < 2; i++) run_period(2048, 1, 2048);

        // period tolerance boundaries
        for (int i = 0; i < 2; i++) run_period(2000, 700, 2000);
        run_period(2046, 700, 2046);
        run_period(2050, 700, 2050);
        run_period(2045, 700, 2045);
        run_period(2051, 700, 2051);

        // randomized periods and high times, including high times above 2047
        for (int i = 0; i < 10; i++) begin
            int p, h;
            p = 2044 + int'($urandom_range(0, 8));
            h = int'($urandom_range(1, p - 1));
            run_period(p, h, p);
        end

        // reset in the middle of a high phase at D=1000
        for (int i = 0; i < 2; i++) run_period(2048, 1000, 2048);
        run_period(2048, 1000, 500);
        do_reset(5);
        for (int i = 0; i < 500; i++) step(1'b1);
        for (int i = 0; i < 1048; i++) step(1'b0);
        for (int i = 0; i < 3; i++) run_period(2048, 1000, 2048);

        // line high across reset release: stuck_hi timeout
        for (int i = 0; i < 10; i++) step(1'b1);
        do_reset(3);
        for (int i = 0; i < 4200; i++) step(1'b1);
        check("stuck_hi_set", stuck_hi, 1);
        check("stuck_lo_clear", stuck_lo, 0);
        check("stuck_hi_duty", duty, 2047);
        for (int i = 0; i < 100; i++) step(1'b0);
        run_period(2048, 300, 2048);
        check("stuck_hi_cleared", stuck_hi, 0);
        run_period(2048, 300, 2048);

        for (int i = 0; i < 10; i++) step(1'b0);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
